// File: rtl/fft_pkg.sv
// Shared helpers for the radix-2 butterfly stage: block geometry, rounding and
// saturation on a common 32-bit signed working width.
package fft_pkg;

  typedef enum logic {
    PH_FILL,
    PH_PAIR
  } phase_t;

  // Beats per half block.
  function automatic int half_beats(input int data, input int num);
    return data / (2 * num);
  endfunction

  function automatic int cnt_width(input int data, input int num);
    return $clog2(2 * half_beats(data, num));
  endfunction

  // Round half up, then drop one LSB.
  function automatic logic signed [31:0] round_half(input logic signed [31:0] value);
    return (value + 32'sd1) >>> 1;
  endfunction

  // Clamp to the signed range representable in width bits.
  function automatic logic signed [31:0] sat_trunc(input logic signed [31:0] value,
                                                   input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

endpackage

// File: rtl/bfly_lane.sv
// One complex butterfly lane: a+b and a-b per component, optional halving,
// then clamp to OUT_WIDTH with a clip indication.
module bfly_lane
  import fft_pkg::*;
#(
  parameter int IN_WIDTH  = 9,
  parameter int OUT_WIDTH = 10
) (
  input  logic [IN_WIDTH-1:0]  a_re,
  input  logic [IN_WIDTH-1:0]  a_im,
  input  logic [IN_WIDTH-1:0]  b_re,
  input  logic [IN_WIDTH-1:0]  b_im,
  input  logic                 scale,
  output logic [OUT_WIDTH-1:0] sum_re,
  output logic [OUT_WIDTH-1:0] sum_im,
  output logic [OUT_WIDTH-1:0] diff_re,
  output logic [OUT_WIDTH-1:0] diff_im,
  output logic                 sat
);

  logic signed [IN_WIDTH-1:0] ar, ai, br, bi;
  logic signed [31:0]         raw [4];
  logic signed [31:0]         res [4];
  logic [3:0]                 clip;

  assign ar = a_re;
  assign ai = a_im;
  assign br = b_re;
  assign bi = b_im;

  always_comb begin
    logic signed [31:0] x;
    x = '0;
    raw[0] = 32'(ar) + 32'(br);
    raw[1] = 32'(ai) + 32'(bi);
    raw[2] = 32'(ar) - 32'(br);
    raw[3] = 32'(ai) - 32'(bi);
    for (int k = 0; k < 4; k++) begin
      x       = scale ? round_half(raw[k]) : raw[k];
      res[k]  = sat_trunc(x, OUT_WIDTH);
      clip[k] = (res[k] != x);
    end
    sum_re  = res[0][OUT_WIDTH-1:0];
    sum_im  = res[1][OUT_WIDTH-1:0];
    diff_re = res[2][OUT_WIDTH-1:0];
    diff_im = res[3][OUT_WIDTH-1:0];
    sat     = |clip;
  end

endmodule

// File: rtl/fft_bfly_stage.sv
// Radix-2 DIF butterfly stage: buffers the first half block, then pairs each
// second-half beat with its buffered partner across NUM parallel lanes.
module fft_bfly_stage
  import fft_pkg::*;
#(
  parameter int IN_WIDTH  = 9,
  parameter int OUT_WIDTH = 10,
  parameter int NUM       = 16,
  parameter int DATA      = 512
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM*IN_WIDTH-1:0]  din_i,
  input  logic [NUM*IN_WIDTH-1:0]  din_q,
  input  logic                     valid_in,
  input  logic                     scale_en,
  output logic [NUM*OUT_WIDTH-1:0] do1_re,
  output logic [NUM*OUT_WIDTH-1:0] do1_im,
  output logic [NUM*OUT_WIDTH-1:0] do2_re,
  output logic [NUM*OUT_WIDTH-1:0] do2_im,
  output logic                     valid_out,
  output logic                     sat_flag,
  output logic                     block_done,
  output logic                     busy
);

  localparam int HB = half_beats(DATA, NUM);
  localparam int CW = cnt_width(DATA, NUM);
  localparam int AW = (HB > 1) ? $clog2(HB) : 1;
  localparam logic [CW-1:0] HB_C   = CW'(HB);
  localparam logic [CW-1:0] LAST_C = CW'(2 * HB - 1);

  if ((DATA % (2 * NUM)) != 0) begin : g_bad_cfg
    $error("fft_bfly_stage: DATA must be a multiple of 2*NUM");
  end

  logic [CW-1:0]           cnt;
  logic                    scale_q;
  phase_t                  phase;
  logic [AW-1:0]           wr_idx, rd_idx;
  logic [NUM*IN_WIDTH-1:0] buf_i [HB];
  logic [NUM*IN_WIDTH-1:0] buf_q [HB];
  logic [NUM*IN_WIDTH-1:0] a_i, a_q;

  logic [NUM*OUT_WIDTH-1:0] s_re, s_im, d_re, d_im;
  logic [NUM-1:0]           lane_sat;

  always_comb begin
    phase  = (cnt >= HB_C) ? PH_PAIR : PH_FILL;
    wr_idx = AW'(cnt);
    rd_idx = AW'(cnt - HB_C);
    busy   = (cnt != '0);
    a_i    = buf_i[rd_idx];
    a_q    = buf_q[rd_idx];
  end

  // Buffer contents survive reset; a discarded partial block is simply overwritten.
  always_ff @(posedge clk) begin
    if (valid_in && phase == PH_FILL) begin
      buf_i[wr_idx] <= din_i;
      buf_q[wr_idx] <= din_q;
    end
  end

  for (genvar k = 0; k < NUM; k++) begin : g_lane
    bfly_lane #(
      .IN_WIDTH (IN_WIDTH),
      .OUT_WIDTH(OUT_WIDTH)
    ) u_lane (
      .a_re   (a_i[k*IN_WIDTH +: IN_WIDTH]),
      .a_im   (a_q[k*IN_WIDTH +: IN_WIDTH]),
      .b_re   (din_i[k*IN_WIDTH +: IN_WIDTH]),
      .b_im   (din_q[k*IN_WIDTH +: IN_WIDTH]),
      .scale  (scale_q),
      .sum_re (s_re[k*OUT_WIDTH +: OUT_WIDTH]),
      .sum_im (s_im[k*OUT_WIDTH +: OUT_WIDTH]),
      .diff_re(d_re[k*OUT_WIDTH +: OUT_WIDTH]),
      .diff_im(d_im[k*OUT_WIDTH +: OUT_WIDTH]),
      .sat    (lane_sat[k])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      scale_q <= 1'b0;
    end else if (valid_in) begin
      cnt <= (cnt == LAST_C) ? '0 : cnt + 1'b1;
      if (cnt == '0) scale_q <= scale_en;
    end
  end

  // Data and sat_flag hold through stalls; only the strobes drop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      do1_re     <= '0;
      do1_im     <= '0;
      do2_re     <= '0;
      do2_im     <= '0;
      valid_out  <= 1'b0;
      sat_flag   <= 1'b0;
      block_done <= 1'b0;
    end else if (valid_in && phase == PH_PAIR) begin
      do1_re     <= s_re;
      do1_im     <= s_im;
      do2_re     <= d_re;
      do2_im     <= d_im;
      valid_out  <= 1'b1;
      sat_flag   <= |lane_sat;
      block_done <= (cnt == LAST_C);
    end else begin
      valid_out  <= 1'b0;
      block_done <= 1'b0;
    end
  end

endmodule
